divider: RTL and testbench

- Iterative radix-2 divider for the RISC-V M-extension ops DIV, DIVU, REM and REMU.
- Instantiated in the EX-stage ALU next to the multiplier.
- Takes 32-bit rs1/rs2 and returns a 32-bit quotient or remainder after a fixed multi-cycle latency.
- Provides the completing-next-cycle signal that hazard_resolution_unit uses to release its stall one cycle early.

---
 rtl/divider.sv | 166 ++++++++++++++++
 tb/tb_divider.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/divider.sv
// Iterative radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU.
// Fixed Width+1 cycle latency from acceptance to the o_valid_output pulse.
module divider #(
  parameter int unsigned Width = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [Width-1:0] i_dividend,
  input  logic [Width-1:0] i_divisor,
  input  logic [1:0]       i_op,
  input  logic             i_valid_input,
  input  logic             i_flush,
  output logic [Width-1:0] o_result,
  output logic             o_valid_output,
  output logic             o_busy,
  output logic             o_completing_next_cycle
);

  localparam int unsigned CntW = (Width > 1) ? $clog2(Width) : 1;
  localparam logic [Width-1:0] MinNeg  = {1'b1, {(Width-1){1'b0}}};
  localparam logic [Width-1:0] AllOnes = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [Width-1:0]  rem_q, rem_d;
  logic [Width-1:0]  quo_q, quo_d;
  logic [Width-1:0]  dvs_q, dvs_d;
  logic [Width-1:0]  dvd_q, dvd_d;
  logic              rem_op_q, rem_op_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;
  logic              dz_q, dz_d;
  logic              ovf_q, ovf_d;
  logic [Width-1:0]  result_q, result_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              comp_q, comp_d;

  logic              is_signed;
  logic              a_neg, b_neg;
  logic [Width:0]    trial, diff;
  logic [Width-1:0]  rem_step, quo_step;
  logic [Width-1:0]  q_fin, r_fin;

  // State and datapath registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      dvd_q    <= '0;
      rem_op_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      comp_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      dvd_q    <= dvd_d;
      rem_op_q <= rem_op_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      comp_q   <= comp_d;
    end
  end

  // Next-state, restoring step and result selection
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    dvd_d    = dvd_q;
    rem_op_d = rem_op_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    ovf_d    = ovf_q;
    result_d = result_q;

    is_signed = ~i_op[0];
    a_neg     = is_signed & i_dividend[Width-1];
    b_neg     = is_signed & i_divisor[Width-1];

    // Partial remainder is Width+1 bits wide so the trial subtract never wraps
    trial    = {rem_q, quo_q[Width-1]};
    diff     = trial - {1'b0, dvs_q};
    rem_step = diff[Width] ? trial[Width-1:0] : diff[Width-1:0];
    quo_step = {quo_q[Width-2:0], ~diff[Width]};

    q_fin = qneg_q ? (~quo_step + Width'(1)) : quo_step;
    r_fin = rneg_q ? (~rem_step + Width'(1)) : rem_step;

    case (state_q)
      IDLE: begin
        if (i_valid_input && !i_flush) begin
          state_d  = CALC;
          cnt_d    = CntW'(Width - 1);
          rem_d    = '0;
          quo_d    = a_neg ? (~i_dividend + Width'(1)) : i_dividend;
          dvs_d    = b_neg ? (~i_divisor + Width'(1)) : i_divisor;
          dvd_d    = i_dividend;
          rem_op_d = i_op[1];
          qneg_d   = a_neg ^ b_neg;
          rneg_d   = a_neg;
          dz_d     = (i_divisor == '0);
          ovf_d    = is_signed && (i_dividend == MinNeg) && (i_divisor == AllOnes);
        end
      end
      CALC: begin
        if (i_flush) begin
          state_d = IDLE;
        end else begin
          rem_d = rem_step;
          quo_d = quo_step;
          cnt_d = cnt_q - CntW'(1);
          if (cnt_q == '0) begin
            state_d = DONE;
            if (dz_q) begin
              result_d = rem_op_q ? dvd_q : AllOnes;
            end else if (ovf_q) begin
              result_d = rem_op_q ? '0 : MinNeg;
            end else begin
              result_d = rem_op_q ? r_fin : q_fin;
            end
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    valid_d = (state_d == DONE);
    busy_d  = (state_d != IDLE);
    comp_d  = (state_d == CALC) && (cnt_d == '0);
  end

  assign o_result                = result_q;
  // A flush in the DONE cycle kills the pulse in that same cycle
  assign o_valid_output          = valid_q & ~i_flush;
  assign o_busy                  = busy_q;
  assign o_completing_next_cycle = comp_q;

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed vectors, random ops against an
// arithmetic reference model, and flush/reset/back-to-back sequences.
module tb_divider;

  localparam int unsigned W = 32;
  localparam int Lat = W + 1;

  logic          clk;
  logic          rst;
  logic [W-1:0]  dividend;
  logic [W-1:0]  divisor;
  logic [1:0]    op;
  logic          vin;
  logic          flush;
  logic [W-1:0]  result;
  logic          vout;
  logic          busy;
  logic          comp;

  int checks   = 0;
  int failures = 0;

  divider #(.Width(W)) dut (
    .i_clk                   (clk),
    .i_rst                   (rst),
    .i_dividend              (dividend),
    .i_divisor               (divisor),
    .i_op                    (op),
    .i_valid_input           (vin),
    .i_flush                 (flush),
    .o_result                (result),
    .o_valid_output          (vout),
    .o_busy                  (busy),
    .o_completing_next_cycle (comp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // RISC-V M-extension semantics straight from the ISA rules
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        min_ovf;
    min_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      2'd0:    r = (b == 0) ? 32'hFFFF_FFFF : min_ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
      2'd1:    r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'd2:    r = (b == 0) ? a : min_ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Drive one request; returns at the sample point of cycle N+1
  task automatic start(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op = o; dividend = a; divisor = b; vin = 1'b1;
    @(posedge clk); #1;
    vin = 1'b0;
  endtask

  // Wait (bounded) for the valid pulse; k0 is the current cycle offset from acceptance
  task automatic wait_res(input int k0, output int lat, output int comp_k, output int comp_n,
                          output logic [31:0] got);
    int k;
    k = k0; lat = -1; comp_k = -1; comp_n = 0; got = '0;
    while (k <= Lat + 8) begin
      if (comp) begin comp_k = k; comp_n++; end
      if (vout) begin lat = k; got = result; break; end
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input bit timing);
    int lat, ck, cn;
    logic [31:0] got;
    start(o, a, b);
    wait_res(1, lat, ck, cn, got);
    check({name, " result"}, got, exp);
    if (timing) begin
      check({name, " latency"}, 32'(lat), 32'(Lat));
      check({name, " completing"}, 32'((cn == 1) ? ck : -1), 32'(Lat - 1));
    end
    @(posedge clk); #1;
    check({name, " single pulse"}, {31'b0, vout}, 32'h0);
  endtask

  initial begin
    int lat, ck, cn, pulses;
    logic [31:0] got, prev, a, b, e;
    logic [1:0]  o;

    vecs[0]  = '{2'd0, 32'd20,          32'hFFFF_FFFD, 32'hFFFF_FFFA, "div 20/-3"};
    vecs[1]  = '{2'd2, 32'd20,          32'hFFFF_FFFD, 32'h0000_0002, "rem 20/-3"};
    vecs[2]  = '{2'd1, 32'hFFFF_FFFF,   32'd2,         32'h7FFF_FFFF, "divu max/2"};
    vecs[3]  = '{2'd3, 32'hFFFF_FFFF,   32'd2,         32'h0000_0001, "remu max/2"};
    vecs[4]  = '{2'd2, 32'hFFFF_FFF9,   32'd2,         32'hFFFF_FFFF, "rem -7/2"};
    vecs[5]  = '{2'd0, 32'd5,           32'd0,         32'hFFFF_FFFF, "div 5/0"};
    vecs[6]  = '{2'd1, 32'h8000_0000,   32'd0,         32'hFFFF_FFFF, "divu min/0"};
    vecs[7]  = '{2'd2, 32'hFFFF_FFF7,   32'd0,         32'hFFFF_FFF7, "rem -9/0"};
    vecs[8]  = '{2'd3, 32'd9,           32'd0,         32'h0000_0009, "remu 9/0"};
    vecs[9]  = '{2'd0, 32'h8000_0000,   32'hFFFF_FFFF, 32'h8000_0000, "div ovf"};
    vecs[10] = '{2'd2, 32'h8000_0000,   32'hFFFF_FFFF, 32'h0000_0000, "rem ovf"};
    vecs[11] = '{2'd1, 32'h8000_0000,   32'hFFFF_FFFF, 32'h0000_0000, "divu ovf operands"};
    vecs[12] = '{2'd3, 32'h8000_0000,   32'hFFFF_FFFF, 32'h8000_0000, "remu ovf operands"};
    vecs[13] = '{2'd0, 32'hFFFF_FFEC,   32'hFFFF_FFFD, 32'h0000_0006, "div -20/-3"};

    rst = 1'b1; vin = 1'b0; flush = 1'b0; op = '0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset result", result, 32'h0);
    check("reset valid", {31'b0, vout}, 32'h0);
    check("reset busy", {31'b0, busy}, 32'h0);
    check("reset completing", {31'b0, comp}, 32'h0);
    rst = 1'b0;

    foreach (vecs[i]) run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b1);

    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'h0;
        1, 2:    b = 32'($urandom_range(1, 15));
        3:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        4:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: b = $urandom;
      endcase
      run_op($sformatf("rand%0d op%0d", i, o), o, a, b, model(o, a, b), 1'b0);
    end

    // Flush at N+10: no pulse, idle at N+11, result held, next op completes
    prev = result;
    pulses = 0;
    start(2'd0, 32'd100, 32'd7);
    repeat (9) begin
      @(posedge clk); #1;
      if (vout) pulses++;
    end
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    if (vout) pulses++;
    check("flush busy low", {31'b0, busy}, 32'h0);
    check("flush result held", result, prev);
    repeat (Lat) begin
      @(posedge clk); #1;
      if (vout) pulses++;
      if (flush) break;
    end
    check("flush no pulse", 32'(pulses), 32'h0);
    run_op("after flush divu 1000/7", 2'd1, 32'd1000, 32'd7, 32'd142, 1'b1);

    // Flush during DONE drops the pulse in that cycle
    start(2'd3, 32'd1000, 32'd7);
    wait_res(1, lat, ck, cn, got);
    check("flush-in-done reached done", 32'(lat), 32'(Lat));
    flush = 1'b1; #1;
    check("flush-in-done pulse dropped", {31'b0, vout}, 32'h0);
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush-in-done idle", {31'b0, busy}, 32'h0);

    // Reset at N+5 clears all outputs at N+6
    start(2'd0, 32'd12345, 32'd3);
    repeat (4) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst mid-op result", result, 32'h0);
    check("rst mid-op valid", {31'b0, vout}, 32'h0);
    check("rst mid-op busy", {31'b0, busy}, 32'h0);
    check("rst mid-op completing", {31'b0, comp}, 32'h0);
    pulses = 0;
    repeat (Lat + 2) begin
      @(posedge clk); #1;
      if (vout) pulses++;
    end
    check("rst mid-op no pulse", 32'(pulses), 32'h0);

    // Back-to-back with a stray request mid-A
    start(2'd0, 32'hFFFF_FF9C, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk);
    op = 2'd1; dividend = 32'd77; divisor = 32'd5; vin = 1'b1;
    @(posedge clk); #1;
    vin = 1'b0;
    wait_res(11, lat, ck, cn, got);
    e = model(2'd0, 32'hFFFF_FF9C, 32'd7);
    check("b2b A result", got, e);
    check("b2b A latency", 32'(lat), 32'(Lat));
    @(posedge clk); #1;
    check("b2b A single pulse", {31'b0, vout}, 32'h0);
    start(2'd2, 32'hFFFF_FF9C, 32'd7);
    wait_res(1, lat, ck, cn, got);
    check("b2b B result", got, model(2'd2, 32'hFFFF_FF9C, 32'd7));
    check("b2b B latency", 32'(lat), 32'(Lat));
    @(posedge clk); #1;
    check("b2b B single pulse", {31'b0, vout}, 32'h0);
    pulses = 0;
    repeat (Lat + 2) begin
      @(posedge clk); #1;
      if (vout) pulses++;
    end
    check("b2b stray ignored", 32'(pulses), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
